// File: rtl/main_mem_ctrl.sv
// Main-memory controller: serializes cache read/write requests against a
// word-addressed array and returns a one-cycle completion after LATENCY cycles.
module main_mem_ctrl #(
    parameter int LATENCY    = 3,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_op,
    input  logic        cache_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] cache_write_data,
    output logic        mem_ready,
    output logic [31:0] mem_data,
    output logic        mem_busy
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state, state_d;
    logic [3:0]              cnt, cnt_d;
    logic                    op_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic                    accept, commit;
    logic [31:0]             mem [WORDS];

    // Byte-offset and alias bits take no part in the word index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:DEPTH_LOG2+2], mem_addr[1:0]};

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (cache_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_ready = (state == DONE);
    assign mem_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            mem_data <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                op_q    <= cache_op;
                idx_q   <= mem_addr[DEPTH_LOG2+1:2];
                wdata_q <= cache_write_data;
            end
            if (commit) begin
                mem_data <= op_q ? mem[idx_q] : wdata_q;
            end
        end
    end

    // Array has no reset; a reset coinciding with the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && !op_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Randomized self-checking bench for main_mem_ctrl: LATENCY=3 and LATENCY=1
// instances share one stimulus stream and are each checked against a request-level model.
module tb_main_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cache_op;
    logic        cache_valid;
    logic [31:0] mem_addr;
    logic [31:0] cache_write_data;
    logic        rdy3, busy3, rdy1, busy1;
    logic [31:0] data3, data1;

    int n_chk  = 0;
    int n_pass = 0;

    main_mem_ctrl #(.LATENCY(3), .DEPTH_LOG2(10)) dut3 (
        .clk(clk), .rst(rst), .cache_op(cache_op), .cache_valid(cache_valid),
        .mem_addr(mem_addr), .cache_write_data(cache_write_data),
        .mem_ready(rdy3), .mem_data(data3), .mem_busy(busy3)
    );

    main_mem_ctrl #(.LATENCY(1), .DEPTH_LOG2(10)) dut1 (
        .clk(clk), .rst(rst), .cache_op(cache_op), .cache_valid(cache_valid),
        .mem_addr(mem_addr), .cache_write_data(cache_write_data),
        .mem_ready(rdy1), .mem_data(data1), .mem_busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Request-level model: a request accepted on edge n completes on edge n+L
    // and the controller is free again after edge n+L+1.
    int unsigned     cyc = 0;
    bit              live = 1'b0;
    int unsigned     lat   [2] = '{3, 1};
    bit              pend  [2];
    int unsigned     acc   [2];
    bit              r_op  [2];
    logic [31:0]     r_addr[2];
    logic [31:0]     r_wd  [2];
    bit              e_rdy [2];
    bit              e_busy[2];
    logic [31:0]     e_data[2];
    bit              e_known[2];
    logic [31:0]     mmem [int unsigned];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pend[k] = 1'b0; e_rdy[k] = 1'b0; e_busy[k] = 1'b0;
                e_data[k] = '0; e_known[k] = 1'b1;
            end else if (!pend[k]) begin
                e_rdy[k] = 1'b0;
                if (cache_valid) begin
                    pend[k] = 1'b1; acc[k] = cyc; e_busy[k] = 1'b1;
                    r_op[k] = cache_op; r_addr[k] = mem_addr; r_wd[k] = cache_write_data;
                end
            end else if (cyc == acc[k] + lat[k]) begin
                int unsigned key;
                key = k * 65536 + ((r_addr[k] >> 2) % 1024);
                if (r_op[k]) begin
                    if (mmem.exists(key)) begin e_data[k] = mmem[key]; e_known[k] = 1'b1; end
                    else e_known[k] = 1'b0;
                end else begin
                    mmem[key] = r_wd[k]; e_data[k] = r_wd[k]; e_known[k] = 1'b1;
                end
                e_rdy[k] = 1'b1;
            end else if (cyc == acc[k] + lat[k] + 1) begin
                pend[k] = 1'b0; e_rdy[k] = 1'b0; e_busy[k] = 1'b0;
            end
        end
        if (rst) live = 1'b1;
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        if (live) begin
            check("rdy_L3", {31'd0, rdy3}, {31'd0, e_rdy[0]});
            check("busy_L3", {31'd0, busy3}, {31'd0, e_busy[0]});
            if (e_known[0]) check("data_L3", data3, e_data[0]);
            check("rdy_L1", {31'd0, rdy1}, {31'd0, e_rdy[1]});
            check("busy_L1", {31'd0, busy1}, {31'd0, e_busy[1]});
            if (e_known[1]) check("data_L1", data1, e_data[1]);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!busy3 && !busy1) return;
            @(negedge clk);
        end
        check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Issues one request and reports, per instance, the index of the
    // post-edge cycle (0 = cycle after acceptance edge) where mem_ready was seen.
    task automatic run_req(input bit op, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] d3, output logic [31:0] d1,
                           output int l3, output int l1);
        wait_idle();
        cache_op = op; mem_addr = addr; cache_write_data = wd; cache_valid = 1'b1;
        l3 = -1; l1 = -1; d3 = '0; d1 = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cache_valid = 1'b0;
                cache_op = 1'($urandom_range(0, 1));
                mem_addr = $urandom;
                cache_write_data = $urandom;
            end
            if (rdy3 && l3 < 0) begin l3 = i; d3 = data3; end
            if (rdy1 && l1 < 0) begin l1 = i; d1 = data1; end
            if (l3 >= 0 && l1 >= 0) break;
        end
        if (l3 < 0 || l1 < 0) check("req_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] d3, d1;
    int          l3, l1;
    logic [5:0]  rv;
    logic [31:0] dd;
    logic        bb, any_rdy;

    initial begin
        rst = 1'b1; cache_valid = 1'b0; cache_op = 1'b0;
        mem_addr = '0; cache_write_data = '0;
        repeat (2) @(negedge clk);
        check("rst_rdy", {31'd0, rdy3}, 32'd0);
        check("rst_busy", {31'd0, busy3}, 32'd0);
        check("rst_data", data3, 32'd0);
        check("rst_data_L1", data1, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic write, then latency and busy release.
        run_req(1'b0, 32'h0, 32'h1111_1111, d3, d1, l3, l1);
        check("wr0_lat", l3, 32'd3);
        check("wr0_data", d3, 32'h1111_1111);
        @(negedge clk);
        check("wr0_busy_after", {31'd0, busy3}, 32'd0);

        run_req(1'b0, 32'h4, 32'h2222_2222, d3, d1, l3, l1);
        run_req(1'b1, 32'h4, 32'h0, d3, d1, l3, l1);
        check("rd4_lat", l3, 32'd3);
        check("rd4_data", d3, 32'h2222_2222);
        run_req(1'b1, 32'h0, 32'h0, d3, d1, l3, l1);
        check("rd0_data", d3, 32'h1111_1111);

        // Aliasing and ignored byte offset.
        run_req(1'b0, 32'h1003, 32'hDEAD_BEEF, d3, d1, l3, l1);
        run_req(1'b1, 32'h0, 32'h0, d3, d1, l3, l1);
        check("alias_rd0", d3, 32'hDEAD_BEEF);
        run_req(1'b1, 32'h1, 32'h0, d3, d1, l3, l1);
        check("alias_rd1", d3, 32'hDEAD_BEEF);
        check("alias_rd1_L1", d1, 32'hDEAD_BEEF);

        // Reset one cycle into BUSY aborts the write.
        run_req(1'b0, 32'h8, 32'h7777_7777, d3, d1, l3, l1);
        wait_idle();
        cache_op = 1'b0; mem_addr = 32'h8; cache_write_data = 32'h5555_5555; cache_valid = 1'b1;
        @(negedge clk);
        cache_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_data", data3, 32'd0);
        check("abort_busy", {31'd0, busy3}, 32'd0);
        any_rdy = rdy3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            any_rdy = any_rdy | rdy3;
        end
        check("abort_no_rdy", {31'd0, any_rdy}, 32'd0);
        run_req(1'b1, 32'h8, 32'h0, d3, d1, l3, l1);
        check("abort_rd8", d3, 32'h7777_7777);
        check("abort_rd8_L1", d1, 32'h7777_7777);
        check("lat1_ready_idx", l1, 32'd1);

        // cache_valid held high with changing inputs during BUSY.
        wait_idle();
        cache_valid = 1'b1; cache_op = 1'b0; mem_addr = 32'h10; cache_write_data = 32'hA5A5_A5A5;
        rv = '0; dd = '0; bb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rv[i] = rdy3;
            if (i == 3) dd = data3;
            if (i == 5) bb = busy3;
            mem_addr = 32'h100 + ($urandom_range(0, 63) << 2);
            cache_write_data = $urandom;
        end
        cache_valid = 1'b0;
        check("hold_rdy_pattern", {26'd0, rv}, 32'h0000_0008);
        check("hold_data", dd, 32'hA5A5_A5A5);
        check("hold_reaccept_busy", {31'd0, bb}, 32'd1);
        run_req(1'b1, 32'h10, 32'h0, d3, d1, l3, l1);
        check("hold_rd10", d3, 32'hA5A5_A5A5);

        // Random traffic with occasional resets and aliased addresses.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 59) == 0);
            cache_valid = 1'($urandom_range(0, 1));
            cache_op = 1'($urandom_range(0, 1));
            mem_addr = ($urandom_range(0, 1) << 12) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            cache_write_data = $urandom;
        end
        @(negedge clk);
        rst = 1'b0; cache_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 Parameter: LATENCY, default 3, request-to-response delay in cycles; legal range 1..15.
REQ-002 Parameter: DEPTH_LOG2, default 10, log2 of the number of 32-bit words in the backing array.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: cache_op  input  1  operation select; 1 = read, 0 = write.
REQ-006 Port: cache_valid  input  1  request strobe from the cache.
REQ-007 Port: mem_addr  input  32  byte address of the request.
REQ-008 Port: cache_write_data  input  32  store data for a write.
REQ-009 Port: mem_ready  output  1  one-cycle completion pulse to the cache.
REQ-010 Port: mem_data  output  32  read data, or echo of the written word on write completion.
REQ-011 Port: mem_busy  output  1  high while a request is outstanding (BUSY or DONE).

Function
REQ-012 SHALL implement an FSM with states IDLE, BUSY and DONE, plus a 4-bit down-counter.
- IDLE with cache_valid=1 at an edge: latch cache_op, mem_addr and cache_write_data; load counter with LATENCY-1; go to BUSY.
- IDLE with cache_valid=0: remain in IDLE.
REQ-013 In BUSY, at each edge:
- counter != 0: decrement the counter.
- counter == 0: perform the array access and go to DONE.
- Net effect: BUSY lasts exactly LATENCY cycles.
REQ-014 In DONE: mem_ready=1 for exactly one cycle; return to IDLE at the next edge.
REQ-015 Completion timing: a request accepted at edge E0 SHALL see mem_ready high in the cycle following edge E0+LATENCY.
REQ-016 Word index SHALL be latched mem_addr[DEPTH_LOG2+1:2].
- Bits [1:0] ignored.
- Bits above DEPTH_LOG2+1 ignored; addresses alias modulo 4*2^DEPTH_LOG2 bytes.
REQ-017 Write commits the latched data to the array at the BUSY->DONE edge; mem_data SHALL equal that written word during DONE.
REQ-018 Read loads mem_data with the array word at the BUSY->DONE edge.
REQ-019 mem_data SHALL hold its value from completion until the next completion or reset.
REQ-020 cache_valid, cache_op, mem_addr and cache_write_data SHALL be ignored in BUSY and DONE.
- The latched copy alone determines the access.
- A new request is accepted only in IDLE; minimum spacing is one IDLE cycle after DONE.
REQ-021 mem_busy SHALL be high in BUSY and DONE, low in IDLE.
REQ-022 A read to a word written by an earlier completed write SHALL return the written value (no bypass path needed; requests are serialized).

Reset
REQ-023 rst=1 at an edge SHALL force: state IDLE, counter 0, mem_ready 0, mem_busy 0, mem_data 32'h0, all latched request registers 0.
REQ-024 Reset SHALL take priority over every other transition, including cache_valid in the same cycle.
REQ-025 Reset asserted in BUSY SHALL abort the request with no array write; a write already committed in DONE stays committed.
REQ-026 Array contents SHALL NOT be cleared by reset; they are undefined at power-up until written.

Verification
REQ-027 LATENCY=3; write 0x1111_1111 to addr 0x0 (cache_valid pulse at edge E0) -> mem_ready high only in the cycle after E3, mem_data=0x1111_1111, mem_busy low after E4.
REQ-028 Write 0x2222_2222 to addr 0x4, then read addr 0x4 -> read completes 3 cycles after acceptance with mem_data=0x2222_2222; addr 0x0 still reads 0x1111_1111.
REQ-029 cache_valid held high continuously with changing mem_addr/cache_write_data during BUSY -> single completion using the values latched at acceptance; next acceptance only in the IDLE cycle after DONE.
REQ-030 Write 0xDEAD_BEEF to addr 0x1003 (DEPTH_LOG2=10) -> a read of 0x0000_0000 returns 0xDEAD_BEEF (alias); a read of 0x1 returns it too (low bits ignored).
REQ-031 rst asserted one cycle into BUSY of a write of 0x5555_5555 to 0x8 -> mem_ready never pulses, outputs reset, and a later read of 0x8 returns the prior value (not 0x5555_5555).
REQ-032 LATENCY=1: read accepted at E0 -> mem_ready high in the cycle after E1.
